// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: decode/execute latch fields in, stall/flush/forward controls out.
interface hazard_ctrl_if;
   logic [4:0] RsD;
   logic [4:0] RtD;
   logic [4:0] RsE;
   logic [4:0] RtE;
   logic [4:0] RdE;
   logic       RegDstE;
   logic       RegWriteE;
   logic       MemtoRegE;
   logic       PCSrcE;
   logic       MemWait;
   logic       StallF;
   logic       StallD;
   logic       FlushD;
   logic       FlushE;
   logic       FreezeE;
   logic [1:0] ForwardAE;
   logic [1:0] ForwardBE;
   logic [4:0] WriteRegM;

   modport master (
      output RsD, RtD, RsE, RtE, RdE, RegDstE, RegWriteE, MemtoRegE, PCSrcE, MemWait,
      input  StallF, StallD, FlushD, FlushE, FreezeE, ForwardAE, ForwardBE, WriteRegM
   );

   modport slave (
      input  RsD, RtD, RsE, RtE, RdE, RegDstE, RegWriteE, MemtoRegE, PCSrcE, MemWait,
      output StallF, StallD, FlushD, FlushE, FreezeE, ForwardAE, ForwardBE, WriteRegM
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use stall, branch flush and M/W forwarding control for the decode/execute latch.
// Optional saturating stall/flush event counters are enabled with HAZARD_STATS_EN.
module hazard_ctrl
`ifdef HAZARD_STATS_EN
   #(parameter int STAT_W = 32)
`endif
(
   input  logic         clk,
   input  logic         rst_n,
   hazard_ctrl_if.slave hz
`ifdef HAZARD_STATS_EN
   ,
   output logic [STAT_W-1:0] StallCnt,
   output logic [STAT_W-1:0] FlushCnt
`endif
);

   typedef enum logic {RUN = 1'b0, LSTALL = 1'b1} state_t;

   state_t     state;
   state_t     nextState;
   logic       regWriteM;
   logic       regWriteW;
   logic [4:0] writeRegW;
   logic [4:0] writeRegE;
   logic       lwStall;

   function automatic logic [1:0] fwdSel(input logic [4:0] src,
                                         input logic       wrM, input logic [4:0] dstM,
                                         input logic       wrW, input logic [4:0] dstW);
      logic [1:0] sel;
      if ((src != 5'd0) && wrM && (dstM == src)) begin
         sel = 2'b10;
      end else if ((src != 5'd0) && wrW && (dstW == src)) begin
         sel = 2'b01;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   assign writeRegE = hz.RegDstE ? hz.RdE : hz.RtE;
   assign lwStall   = hz.MemtoRegE & hz.RegWriteE & (writeRegE != 5'd0) &
                      ((writeRegE == hz.RsD) | (writeRegE == hz.RtD));

   // Shadow M/W destination copies; a memory wait freezes them along with the pipe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regWriteM    <= 1'b0;
         hz.WriteRegM <= 5'd0;
         regWriteW    <= 1'b0;
         writeRegW    <= 5'd0;
      end else if (!hz.MemWait) begin
         regWriteM    <= hz.RegWriteE;
         hz.WriteRegM <= writeRegE;
         regWriteW    <= regWriteM;
         writeRegW    <= hz.WriteRegM;
      end
   end

   // Stall-episode state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
      end else begin
         state <= nextState;
      end
   end

   // Next state; a load-use seen while already in LSTALL is a protocol error but is still honoured.
   always_comb begin
      nextState = state;
      if (hz.MemWait) begin
         nextState = state;
      end else begin
         case (state)
            RUN:     nextState = (lwStall && !hz.PCSrcE) ? LSTALL : RUN;
            LSTALL:  nextState = (lwStall && !hz.PCSrcE) ? LSTALL : RUN;
            default: nextState = RUN;
         endcase
      end
   end

   // Control outputs with priority MemWait > branch flush > load-use; all held low in reset.
   always_comb begin
      hz.StallF    = 1'b0;
      hz.StallD    = 1'b0;
      hz.FlushD    = 1'b0;
      hz.FlushE    = 1'b0;
      hz.FreezeE   = 1'b0;
      hz.ForwardAE = 2'b00;
      hz.ForwardBE = 2'b00;
      if (!rst_n) begin
         hz.StallF = 1'b0;
      end else begin
         hz.ForwardAE = fwdSel(hz.RsE, regWriteM, hz.WriteRegM, regWriteW, writeRegW);
         hz.ForwardBE = fwdSel(hz.RtE, regWriteM, hz.WriteRegM, regWriteW, writeRegW);
         if (hz.MemWait) begin
            hz.StallF  = 1'b1;
            hz.StallD  = 1'b1;
            hz.FreezeE = 1'b1;
         end else if (hz.PCSrcE) begin
            hz.FlushD = 1'b1;
            hz.FlushE = 1'b1;
         end else if (lwStall) begin
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.FlushE = 1'b1;
         end else begin
            hz.StallF = 1'b0;
         end
      end
   end

`ifdef HAZARD_STATS_EN
   localparam logic [STAT_W-1:0] CntMax = {STAT_W{1'b1}};
   localparam logic [STAT_W-1:0] CntOne = {{(STAT_W-1){1'b0}}, 1'b1};

   // Saturating hazard event counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         StallCnt <= {STAT_W{1'b0}};
         FlushCnt <= {STAT_W{1'b0}};
      end else begin
         if (hz.StallD && !hz.MemWait && (StallCnt != CntMax)) begin
            StallCnt <= StallCnt + CntOne;
         end
         if (hz.FlushD && (FlushCnt != CntMax)) begin
            FlushCnt <= FlushCnt + CntOne;
         end
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, async reset case, random run vs model.
module tb_hazard_ctrl;

   logic clk;
   logic rst_n;
   hazard_ctrl_if hz();

`ifdef HAZARD_STATS_EN
   logic [31:0] stallCnt;
   logic [31:0] flushCnt;
   logic [1:0]  stallCnt2;
   logic [1:0]  flushCnt2;
   hazard_ctrl_if hz2();
   assign hz2.RsD = hz.RsD;           assign hz2.RtD = hz.RtD;
   assign hz2.RsE = hz.RsE;           assign hz2.RtE = hz.RtE;
   assign hz2.RdE = hz.RdE;           assign hz2.RegDstE = hz.RegDstE;
   assign hz2.RegWriteE = hz.RegWriteE; assign hz2.MemtoRegE = hz.MemtoRegE;
   assign hz2.PCSrcE = hz.PCSrcE;     assign hz2.MemWait = hz.MemWait;
   hazard_ctrl #(.STAT_W(32)) dut (.clk(clk), .rst_n(rst_n), .hz(hz),
                                   .StallCnt(stallCnt), .FlushCnt(flushCnt));
   hazard_ctrl #(.STAT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .hz(hz2),
                                   .StallCnt(stallCnt2), .FlushCnt(flushCnt2));
`else
   hazard_ctrl dut (.clk(clk), .rst_n(rst_n), .hz(hz));
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] rsD, rtD, rsE, rtE, rdE;
      logic       dst, wr, mtr, pc, mw;
      logic       sF, sD, fD, fE, frz;
      logic [1:0] fa, fb;
      logic [4:0] wrm;
   } vec_t;

   typedef struct {
      logic       sF, sD, fD, fE, frz;
      logic [1:0] fa, fb;
      logic [4:0] wrm;
   } out_t;

   typedef struct {
      logic       wr;
      logic [4:0] dst;
   } slot_t;

   int    total = 0;
   int    bad   = 0;
   slot_t pipe[2];      // model shadow: [0] = M stage, [1] = W stage
   longint sc = 0;
   longint fc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end
   endtask

   task automatic clearModel();
      for (int s = 0; s < 2; s++) pipe[s] = '{wr: 1'b0, dst: 5'd0};
      sc = 0;
      fc = 0;
   endtask

   function automatic logic [1:0] fwd(input logic [4:0] src);
      for (int s = 0; s < 2; s++)
         if (src != 5'd0 && pipe[s].wr && pipe[s].dst == src) return (s == 0) ? 2'b10 : 2'b01;
      return 2'b00;
   endfunction

   function automatic out_t model();
      out_t       o;
      logic [4:0] dE;
      logic       ld;
      o = '{sF: 1'b0, sD: 1'b0, fD: 1'b0, fE: 1'b0, frz: 1'b0, fa: 2'b00, fb: 2'b00, wrm: 5'd0};
      if (!rst_n) return o;
      dE = hz.RegDstE ? hz.RdE : hz.RtE;
      ld = hz.MemtoRegE && hz.RegWriteE && dE != 5'd0 && (dE == hz.RsD || dE == hz.RtD);
      if (hz.MemWait)      begin o.sF = 1'b1; o.sD = 1'b1; o.frz = 1'b1; end
      else if (hz.PCSrcE)  begin o.fD = 1'b1; o.fE = 1'b1; end
      else if (ld)         begin o.sF = 1'b1; o.sD = 1'b1; o.fE = 1'b1; end
      o.fa  = fwd(hz.RsE);
      o.fb  = fwd(hz.RtE);
      o.wrm = pipe[0].dst;
      return o;
   endfunction

   task automatic modelEdge();
      out_t e;
      e = model();
      if (!rst_n) begin
         clearModel();
      end else begin
         if (e.sD && !hz.MemWait) sc++;
         if (e.fD) fc++;
         if (!hz.MemWait) begin
            pipe[1] = pipe[0];
            pipe[0] = '{wr: hz.RegWriteE, dst: (hz.RegDstE ? hz.RdE : hz.RtE)};
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   task automatic checkOuts(input string tag, input out_t e);
      chk({tag, ".StallF"},    32'(hz.StallF),    32'(e.sF));
      chk({tag, ".StallD"},    32'(hz.StallD),    32'(e.sD));
      chk({tag, ".FlushD"},    32'(hz.FlushD),    32'(e.fD));
      chk({tag, ".FlushE"},    32'(hz.FlushE),    32'(e.fE));
      chk({tag, ".FreezeE"},   32'(hz.FreezeE),   32'(e.frz));
      chk({tag, ".ForwardAE"}, 32'(hz.ForwardAE), 32'(e.fa));
      chk({tag, ".ForwardBE"}, 32'(hz.ForwardBE), 32'(e.fb));
      chk({tag, ".WriteRegM"}, 32'(hz.WriteRegM), 32'(e.wrm));
   endtask

   task automatic drive(input vec_t v);
      hz.RsD = v.rsD; hz.RtD = v.rtD; hz.RsE = v.rsE; hz.RtE = v.rtE; hz.RdE = v.rdE;
      hz.RegDstE = v.dst; hz.RegWriteE = v.wr; hz.MemtoRegE = v.mtr;
      hz.PCSrcE = v.pc; hz.MemWait = v.mw;
   endtask

   task automatic randomInputs();
      hz.RsD = 5'($urandom_range(0, 3)); hz.RtD = 5'($urandom_range(0, 3));
      hz.RsE = 5'($urandom_range(0, 3)); hz.RtE = 5'($urandom_range(0, 3));
      hz.RdE = 5'($urandom_range(0, 3));
      hz.RegDstE   = 1'($urandom_range(0, 1));
      hz.RegWriteE = ($urandom_range(0, 3) != 0);
      hz.MemtoRegE = 1'($urandom_range(0, 1));
      hz.PCSrcE    = ($urandom_range(0, 5) == 0);
      hz.MemWait   = ($urandom_range(0, 7) == 0);
   endtask

   vec_t tbl[$];
   vec_t bub;
   vec_t ldUse;

   initial begin
      //                rsD rtD rsE rtE rdE dst wr mtr pc mw  sF sD fD fE frz fa fb wrm
      tbl.push_back('{5'd0, 5'd0, 5'd0, 5'd0, 5'd8, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 5'd0});
      tbl.push_back('{5'd0, 5'd0, 5'd8, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 5'd8});
      tbl.push_back('{5'd9, 5'd0, 5'd8, 5'd9, 5'd0, 0, 1, 1, 0, 0, 1, 1, 0, 1, 0, 2'd1, 2'd0, 5'd0});
      tbl.push_back('{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 5'd9});
      tbl.push_back('{5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 5'd0});
      tbl.push_back('{5'd0, 5'd0, 5'd5, 5'd0, 5'd5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 5'd5});
      tbl.push_back('{5'd0, 5'd0, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd2, 5'd5});
      tbl.push_back('{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 5'd5});
      tbl.push_back('{5'd0, 5'd7, 5'd0, 5'd7, 5'd0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 5'd0});
      tbl.push_back('{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 5'd7});
      tbl.push_back('{5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 5'd0});
      tbl.push_back('{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 5'd7});
      // load-use held by a 3-cycle memory wait, then released, then a bubble
      for (int k = 0; k < 3; k++)
         tbl.push_back('{5'd9, 5'd0, 5'd0, 5'd9, 5'd0, 0, 1, 1, 0, 1, 1, 1, 0, 0, 1, 2'd0, 2'd0, 5'd0});
      tbl.push_back('{5'd9, 5'd0, 5'd0, 5'd9, 5'd0, 0, 1, 1, 0, 0, 1, 1, 0, 1, 0, 2'd0, 2'd0, 5'd0});
      tbl.push_back('{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 5'd9});

      bub   = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 5'd0};
      ldUse = '{5'd9, 5'd0, 5'd0, 5'd9, 5'd0, 0, 1, 1, 0, 0, 1, 1, 0, 1, 0, 2'd0, 2'd0, 5'd0};

      // reset held with random inputs: everything reads 0
      rst_n = 1'b0;
      clearModel();
      randomInputs();
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         randomInputs();
         #3;
         checkOuts($sformatf("rst%0d", i), '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'd0});
         tick();
      end
      rst_n = 1'b1;

      // directed table, expectations hand-derived
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i]);
         #3;
         checkOuts($sformatf("vec%0d", i),
                   '{tbl[i].sF, tbl[i].sD, tbl[i].fD, tbl[i].fE, tbl[i].frz,
                     tbl[i].fa, tbl[i].fb, tbl[i].wrm});
         tick();
      end

      // reset asserted in the middle of a stall drops outputs at once
      drive(ldUse);
      #2;
      chk("preRst.StallD", 32'(hz.StallD), 32'd1);
      rst_n = 1'b0;
      clearModel();
      #1;
      checkOuts("asyncRst", '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'd0});
      tick();
      rst_n = 1'b1;
      drive(bub);
      #3;
      checkOuts("postRst", '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'd0});
      tick();

      // randomized run against the reference model
      for (int i = 0; i < 400; i++) begin
         randomInputs();
         #3;
         checkOuts($sformatf("rnd%0d", i), model());
         tick();
      end

`ifdef HAZARD_STATS_EN
      drive(bub);
      #3;
      chk("StallCnt", stallCnt, 32'(sc));
      chk("FlushCnt", flushCnt, 32'(fc));
      chk("StallCntSat", 32'(stallCnt2), (sc > 3) ? 32'd3 : 32'(sc));
      chk("FlushCntSat", 32'(flushCnt2), (fc > 3) ? 32'd3 : 32'(fc));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Reverse-direction controller for the decode/execute pipeline register. It reads the E-stage fields that the decode/execute latch presents and the D-stage source registers. It drives stall and flush back into the fetch/decode/execute latches and forwarding selects into the execute datapath. It keeps its own shadow copy of the M and W stage destination and control bits so forwarding is resolved without extra latch ports.

Parameters:
STAT_W, 32, width of the optional hazard event counters.

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
RsD  in  5  D-stage source register rs
RtD  in  5  D-stage source register rt
RsE  in  5  E-stage rs from the decode/execute latch
RtE  in  5  E-stage rt from the decode/execute latch
RdE  in  5  E-stage rd from the decode/execute latch
RegDstE  in  1  1 = dest is RdE, 0 = dest is RtE
RegWriteE  in  1  E-stage instruction writes the register file
MemtoRegE  in  1  E-stage instruction is a load
PCSrcE  in  1  branch resolved taken in E this cycle
MemWait  in  1  data memory not ready; freeze the whole pipe
StallF  out  1  hold PC
StallD  out  1  hold the fetch/decode latch
FlushD  out  1  clear the fetch/decode latch
FlushE  out  1  load a bubble into the decode/execute latch
FreezeE  out  1  hold the decode/execute latch and downstream
ForwardAE  out  2  ALU A select: 00 reg file, 10 from M, 01 from W
ForwardBE  out  2  ALU B select, same encoding
WriteRegM  out  5  shadow M-stage destination, exposed for debug

Behaviour:
- Clocking and reset:
  - Single clock domain. Reset is asynchronous and active-low.
  - On reset: shadow M/W registers (RegWrite, MemtoReg, WriteReg) = 0, state = RUN, counters = 0.
  - All outputs therefore read 0 during reset.
- WriteRegE = RegDstE ? RdE : RtE (combinational).
- Shadow pipeline, updated each rising edge unless MemWait = 1:
  - M <= {RegWriteE, MemtoRegE, WriteRegE}.
  - W <= M.
  - MemWait = 1 holds M and W unchanged.
- Load-use hazard: lwstall = MemtoRegE & RegWriteE & (WriteRegE != 0) & ((WriteRegE == RsD) | (WriteRegE == RtD)).
- Branch hazard: brflush = PCSrcE.
- Outputs are combinational from inputs and shadow state, with zero-cycle latency:
  - StallF = StallD = lwstall & ~brflush & ~MemWait.
  - FlushE = (lwstall | brflush) & ~MemWait.
  - FlushD = brflush & ~MemWait.
  - FreezeE = MemWait; when asserted it forces StallF = StallD = 1 and FlushD = FlushE = 0.
- Priority: MemWait > branch flush > load-use stall. A simultaneous taken branch and load-use gives flush only, with no stall.
- Forwarding for operand A:
  - ForwardAE = 10 if RegWriteM & WriteRegM != 0 & WriteRegM == RsE.
  - else 01 if RegWriteW & WriteRegW != 0 & WriteRegW == RsE.
  - else 00.
- ForwardBE uses the same rule with RtE. M has priority over W.
- Register 0 never forwards and never stalls.
- State machine, tracks stall episodes:
  - RUN -> LSTALL when lwstall & ~brflush & ~MemWait.
  - LSTALL -> RUN on the next non-MemWait edge.
  - While in LSTALL, a new lwstall is a protocol error (the bubble guarantees none). The next lwstall is still honoured and the state remains LSTALL.
- Reset asserted mid-stall returns to RUN immediately; outputs drop to 0 asynchronously.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined:
  - Adds outputs StallCnt[STAT_W-1:0] and FlushCnt[STAT_W-1:0].
  - StallCnt increments on each edge where StallD & ~MemWait.
  - FlushCnt increments on each edge where FlushD.
  - Both counters saturate at all-ones and clear on reset.
- When undefined: neither the ports nor the counter logic exist; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n = 0 with random inputs -> all outputs 0. Release, then feed E: RegWriteE = 1, RegDstE = 1, RdE = 8. After 1 edge, WriteRegM = 8.
- Load-use: MemtoRegE = 1, RegWriteE = 1, RegDstE = 0, RtE = 9, RsD = 9 -> same cycle StallF = StallD = FlushE = 1, FlushD = 0. Next cycle with a bubble in E -> all 0.
- Forwarding priority: M dest = 5 and W dest = 5, both writing, RsE = 5 -> ForwardAE = 10. Then RegWriteM = 0 -> ForwardAE = 01. Any case with RsE = 0 -> ForwardAE = 00.
- Branch vs load-use: PCSrcE = 1 together with a load-use match -> FlushD = FlushE = 1, StallF = StallD = 0.
- MemWait: assert for 3 cycles during a load-use -> FreezeE = 1, StallF = StallD = 1, flushes 0, WriteRegM unchanged for 3 edges. Release -> the stall resolves the next cycle.
- HAZARD_STATS_EN: 2 load-use stalls plus 1 taken branch -> StallCnt = 2, FlushCnt = 1. Force STAT_W = 2 and 5 stalls -> StallCnt = 3, saturated.
